// File: rtl/pattern_sweep_pkg.sv
// Shared FSM encoding, LFSR/MISR tap constants and the LFSR step function
// used by the pattern sweep engine.
package pattern_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } sweep_state_e;

    // Maximal-length tap masks, indexed by register width; bit k set means stage k+1 feeds back.
    localparam logic [31:0] LFSR_TAPS [0:32] = '{
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0006,
        32'h0000_000C, 32'h0000_0014, 32'h0000_0030, 32'h0000_0060,
        32'h0000_00B8, 32'h0000_0110, 32'h0000_0240, 32'h0000_0500,
        32'h0000_0829, 32'h0000_100D, 32'h0000_2015, 32'h0000_6000,
        32'h0000_D008, 32'h0001_2000, 32'h0002_0400, 32'h0004_0023,
        32'h0009_0000, 32'h0014_0000, 32'h0030_0000, 32'h0042_0000,
        32'h00E1_0000, 32'h0120_0000, 32'h0200_0023, 32'h0400_0013,
        32'h0900_0000, 32'h1400_0000, 32'h2000_0029, 32'h4800_0000,
        32'h8020_0003
    };

    // Galois feedback mask for the signature register; only the low OUT_W+16 bits are used.
    localparam logic [47:0] MISR_TAPS = 48'h8000_0000_002D;

    function automatic logic [31:0] lfsr_next(input logic [31:0] vec, input logic [5:0] width);
        logic [31:0] mask;
        logic        fb;
        mask = (width >= 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        fb   = ^(vec & LFSR_TAPS[width]);
        return ((vec << 1) | {31'd0, fb}) & mask;
    endfunction

endpackage

// File: rtl/sweep_lfsr.sv
// Fibonacci LFSR stimulus register: load has priority over step, new value one edge later.
// No backpressure of its own; the caller decides when to step.
module sweep_lfsr
    import pattern_sweep_pkg::*;
#(
    parameter int IN_W = 5
) (
    input  logic            clock,
    input  logic            rst_n,
    input  logic            load,
    input  logic [IN_W-1:0] seed,
    input  logic            step,
    output logic [IN_W-1:0] value
);

    logic [IN_W-1:0] value_q;
    logic [IN_W-1:0] value_d;
    logic [31:0]     step_ext;

    always_comb begin
        step_ext = lfsr_next(32'(value_q), 6'(IN_W));
        value_d  = value_q;
        if (load) begin
            value_d = seed;
        end else if (step) begin
            value_d = step_ext[IN_W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/pattern_sweep_gen.sv
// Sweeps stimulus into a combinational DUT, captures its response SETTLE_CYC edges later and emits one record
// per vector on valid/ready (held while rec_ready is low). Optional signature port: PATTERN_SWEEP_SIGNATURE_EN.
module pattern_sweep_gen
    import pattern_sweep_pkg::*;
#(
    parameter int IN_W        = 5,
    parameter int OUT_W       = 2,
    parameter int CNT_W       = 18,
    parameter int NUM_VECTORS = 70000,
    parameter int SETTLE_CYC  = 1
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [IN_W-1:0]   seed,
    output logic [IN_W-1:0]   dut_in,
    input  logic [OUT_W-1:0]  dut_out,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [CNT_W-1:0]  rec_index,
    output logic [IN_W-1:0]   rec_stim,
    output logic [OUT_W-1:0]  rec_resp,
`ifdef PATTERN_SWEEP_SIGNATURE_EN
    output logic [OUT_W+15:0] signature,
`endif
    output logic              busy,
    output logic              done
);

    localparam int               SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(NUM_VECTORS - 1);

    sweep_state_e     state_q, state_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [CNT_W-1:0] index_q, index_d;
    logic             mode_q, mode_d;
    logic [IN_W-1:0]  cnt_q, cnt_d;
    logic             rec_valid_q, rec_valid_d;
    logic [CNT_W-1:0] rec_index_q, rec_index_d;
    logic [IN_W-1:0]  rec_stim_q, rec_stim_d;
    logic [OUT_W-1:0] rec_resp_q, rec_resp_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept;
    logic             handshake;
    logic             lfsr_load;
    logic             lfsr_step;
    logic [IN_W-1:0]  lfsr_seed;
    logic [IN_W-1:0]  lfsr_val;

    // An all-zero LFSR would lock up, so a zero seed starts the random sweep at 1.
    assign lfsr_seed = (seed == '0) ? IN_W'(1) : seed;

    sweep_lfsr #(.IN_W(IN_W)) u_lfsr (
        .clock (clock),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .seed  (lfsr_seed),
        .step  (lfsr_step),
        .value (lfsr_val)
    );

    assign dut_in = mode_q ? lfsr_val : cnt_q;

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        index_d     = index_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        rec_valid_d = rec_valid_q;
        rec_index_d = rec_index_q;
        rec_stim_d  = rec_stim_q;
        rec_resp_d  = rec_resp_q;
        busy_d      = busy_q;
        done_d      = done_q;
        accept      = 1'b0;
        handshake   = 1'b0;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    lfsr_load = 1'b1;
                    mode_d    = mode;
                    cnt_d     = seed;
                    index_d   = '0;
                    settle_d  = SETTLE_LOAD;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_q == '0) begin
                    rec_valid_d = 1'b1;
                    rec_index_d = index_q;
                    rec_stim_d  = dut_in;
                    rec_resp_d  = dut_out;
                    state_d     = CAPTURE;
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
            CAPTURE: begin
                if (rec_valid_q && rec_ready) begin
                    handshake   = 1'b1;
                    rec_valid_d = 1'b0;
                    if (index_q == LAST_IDX) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        index_d   = index_q + CNT_W'(1);
                        cnt_d     = mode_q ? cnt_q : cnt_q + IN_W'(1);
                        lfsr_step = mode_q;
                        settle_d  = SETTLE_LOAD;
                        state_d   = SETTLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            settle_q    <= '0;
            index_q     <= '0;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            rec_valid_q <= 1'b0;
            rec_index_q <= '0;
            rec_stim_q  <= '0;
            rec_resp_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            index_q     <= index_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            rec_valid_q <= rec_valid_d;
            rec_index_q <= rec_index_d;
            rec_stim_q  <= rec_stim_d;
            rec_resp_q  <= rec_resp_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rec_valid = rec_valid_q;
    assign rec_index = rec_index_q;
    assign rec_stim  = rec_stim_q;
    assign rec_resp  = rec_resp_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef PATTERN_SWEEP_SIGNATURE_EN
    localparam int            SG       = OUT_W + 16;
    localparam logic [SG-1:0] SIG_TAPS = SG'(MISR_TAPS);

    logic [SG-1:0] sig_q, sig_d;

    // Folds each accepted record in; the value is final once done rises.
    always_comb begin
        sig_d = sig_q;
        if (accept) begin
            sig_d = '0;
        end else if (handshake) begin
            sig_d = {sig_q[SG-2:0], 1'b0} ^ (sig_q[SG-1] ? SIG_TAPS : '0)
                  ^ {rec_resp_q, 16'(rec_index_q)};
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign signature = sig_q;
`endif

endmodule

// File: tb/tb_pattern_sweep_gen.sv
// Scoreboarded bench for pattern_sweep_gen driving a c17 model: counter and LFSR sweeps,
// backpressure, reset abort, ignored mid-sweep start and a slow DUT with a longer settle time.
`timescale 1ns/1ps
module tb_pattern_sweep_gen;
`ifdef PATTERN_SWEEP_SIGNATURE_EN
    import pattern_sweep_pkg::*;
`endif

    localparam int IN_W  = 5;
    localparam int OUT_W = 2;
    localparam int CNT_W = 18;
    localparam int NV    = 40;
    localparam int NV4   = 8;
    localparam int SG    = OUT_W + 16;

    // c17 truth table, hand-derived: entry v = {N23, N22} for input {N7,N6,N3,N2,N1} = v.
    localparam logic [1:0] C17_TT [32] = '{
        2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd1, 2'd3, 2'd3,
        2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd1, 2'd0, 2'd1,
        2'd2, 2'd2, 2'd3, 2'd3, 2'd2, 2'd3, 2'd3, 2'd3,
        2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd1, 2'd0, 2'd1
    };

    typedef struct packed {
        logic [CNT_W-1:0] idx;
        logic [IN_W-1:0]  stim;
        logic [OUT_W-1:0] resp;
    } rec_t;

    logic              clock = 1'b0;
    logic              rst_n, start, mode, rec_ready, flip;
    logic [IN_W-1:0]   seed, dut_in, rec_stim;
    logic [OUT_W-1:0]  dut_out, rec_resp;
    logic [CNT_W-1:0]  rec_index;
    logic              rec_valid, busy, done;

    logic              start4, mode4, rec_ready4;
    logic [IN_W-1:0]   seed4, dut_in4, rec_stim4;
    logic [OUT_W-1:0]  dut_out4, rec_resp4;
    logic [CNT_W-1:0]  rec_index4;
    logic              rec_valid4, busy4, done4;
`ifdef PATTERN_SWEEP_SIGNATURE_EN
    logic [SG-1:0]     sig, sig4, sig_model, sig_ref;
`endif

    rec_t              exp_q[$];
    rec_t              exp4_q[$];
    rec_t              e_m, e_m4;
    logic [IN_W-1:0]   stim_log [64];
    logic [IN_W-1:0]   prev_in4 = '0;
    logic              prev_v4 = 1'b0;
    logic              period_chk;
    int                n_vec = 0;
    int                n_err = 0;
    int                cyc = 0;
    int                last_hs = 0;
    int                chg4 = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [1:0] c17(input logic [4:0] v);
        logic n10, n11, n16, n19;
        n10 = ~(v[0] & v[2]);
        n11 = ~(v[2] & v[3]);
        n16 = ~(v[1] & n11);
        n19 = ~(n11 & v[4]);
        return {~(n16 & n19), ~(n10 & n16)};
    endfunction

    function automatic logic [4:0] lfsr5(input logic [4:0] v);
        return {v[3:0], v[4] ^ v[2]};
    endfunction

`ifdef PATTERN_SWEEP_SIGNATURE_EN
    function automatic logic [SG-1:0] misr(input logic [SG-1:0] s, input logic [SG-1:0] d);
        logic [SG-1:0] taps;
        taps = SG'(MISR_TAPS);
        return {s[SG-2:0], 1'b0} ^ (s[SG-1] ? taps : '0) ^ d;
    endfunction
`endif

    assign dut_out = c17(dut_in) ^ {1'b0, flip};

    // Slow DUT for the second instance: response appears three edges after its input.
    logic [1:0] p1, p2, p3;
    always @(posedge clock) begin
        p1 <= c17(dut_in4);
        p2 <= p1;
        p3 <= p2;
    end
    assign dut_out4 = p3;

    pattern_sweep_gen #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .NUM_VECTORS(NV), .SETTLE_CYC(1)) u_dut (
        .clock(clock), .rst_n(rst_n), .start(start), .mode(mode), .seed(seed),
        .dut_in(dut_in), .dut_out(dut_out), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_index(rec_index), .rec_stim(rec_stim), .rec_resp(rec_resp),
`ifdef PATTERN_SWEEP_SIGNATURE_EN
        .signature(sig),
`endif
        .busy(busy), .done(done)
    );

    pattern_sweep_gen #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .NUM_VECTORS(NV4), .SETTLE_CYC(4)) u_dut4 (
        .clock(clock), .rst_n(rst_n), .start(start4), .mode(mode4), .seed(seed4),
        .dut_in(dut_in4), .dut_out(dut_out4), .rec_valid(rec_valid4), .rec_ready(rec_ready4),
        .rec_index(rec_index4), .rec_stim(rec_stim4), .rec_resp(rec_resp4),
`ifdef PATTERN_SWEEP_SIGNATURE_EN
        .signature(sig4),
`endif
        .busy(busy4), .done(done4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic push_run(input logic m, input logic [4:0] s, input int n, input logic f);
        logic [4:0] v;
        rec_t       r;
        v = (m && s == 5'd0) ? 5'd1 : s;
`ifdef PATTERN_SWEEP_SIGNATURE_EN
        sig_model = '0;
`endif
        for (int i = 0; i < n; i++) begin
            r.idx  = CNT_W'(i);
            r.stim = v;
            r.resp = C17_TT[v] ^ {1'b0, f};
            exp_q.push_back(r);
`ifdef PATTERN_SWEEP_SIGNATURE_EN
            sig_model = misr(sig_model, {r.resp, 16'(r.idx)});
`endif
            v = m ? lfsr5(v) : v + 5'd1;
        end
    endtask

    // Entered and left one time unit after a rising edge.
    task automatic pulse_start(input logic m, input logic [4:0] s);
        start = 1'b1;
        mode  = m;
        seed  = s;
        @(posedge clock); #1;
        start = 1'b0;
        mode  = ~m;
        seed  = ~s;
    endtask

    task automatic wait_idx(input logic [CNT_W-1:0] t, input int budget, output bit found);
        found = 1'b0;
        for (int k = 0; k < budget && !found; k++) begin
            if (rec_valid && rec_index == t) found = 1'b1;
            else begin
                @(posedge clock); #1;
            end
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(posedge clock); #1;
            k++;
        end
        chk({name, "_done"}, 64'(done), 64'd1);
        chk({name, "_busy"}, 64'(busy), 64'd0);
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    always @(negedge clock) begin
        if (rst_n && rec_valid && rec_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_record: got index %0d, want no record", rec_index);
            end else begin
                e_m = exp_q.pop_front();
                chk("record", {rec_index, rec_stim, rec_resp}, 64'(e_m));
                if (period_chk && rec_index != '0) chk("period", 64'(cyc - last_hs), 64'd2);
                last_hs = cyc;
                stim_log[rec_index[5:0]] = rec_stim;
            end
        end
    end

    always @(negedge clock) begin
        if (dut_in4 != prev_in4) chg4 = cyc;
        prev_in4 = dut_in4;
        if (rst_n && rec_valid4 && !prev_v4) chk("settle_latency", 64'(cyc - chg4), 64'd4);
        prev_v4 = rec_valid4;
        if (rst_n && rec_valid4 && rec_ready4) begin
            if (exp4_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_record4: got index %0d, want no record", rec_index4);
            end else begin
                e_m4 = exp4_q.pop_front();
                chk("record4", {rec_index4, rec_stim4, rec_resp4}, 64'(e_m4));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, want completion within 200us");
        $fatal(1, "bench timed out");
    end

    initial begin
        bit         found, seen;
        int         k, bad;
        logic [31:0] seen_set;
        logic [4:0]  v4;

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; seed = '0; rec_ready = 1'b1; flip = 1'b0;
        start4 = 1'b0; mode4 = 1'b0; seed4 = 5'd30; rec_ready4 = 1'b1; period_chk = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_dut_in", 64'(dut_in), 64'd0);
        chk("rst_rec_valid", 64'(rec_valid), 64'd0);
        chk("rst_rec_index", 64'(rec_index), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(posedge clock); #1;

        // Exhaustive counter, seed 0: stims 0..31 then 0..7 at full rate.
        push_run(1'b0, 5'd0, NV, 1'b0);
        period_chk = 1'b1;
        pulse_start(1'b0, 5'd0);
        chk("t1_busy_after_start", 64'(busy), 64'd1);
        chk("t1_first_dut_in", 64'(dut_in), 64'd0);
        wait_done("t1", 200);
        period_chk = 1'b0;
        chk("t1_dut_in_hold", 64'(dut_in), 64'd7);
        chk("t1_valid_low", 64'(rec_valid), 64'd0);

        // LFSR mode, seed 0 forced to 1; period 31 so record 31 repeats the first stim.
        push_run(1'b1, 5'd0, NV, 1'b0);
        pulse_start(1'b1, 5'd0);
        chk("t2_first_dut_in", 64'(dut_in), 64'd1);
        wait_done("t2", 200);
        chk("t2_log0", 64'(stim_log[0]), 64'd1);
        bad = 0;
        seen_set = '0;
        for (int i = 0; i < 31; i++) begin
            if (stim_log[i] == 5'd0 || seen_set[stim_log[i]]) bad++;
            seen_set[stim_log[i]] = 1'b1;
        end
        chk("t2_distinct_nonzero", 64'(bad), 64'd0);
        chk("t2_wrap_repeat", 64'(stim_log[31]), 64'd1);

        // Backpressure at index 3 with seed 5: record and dut_in frozen at stim 8.
        push_run(1'b0, 5'd5, NV, 1'b0);
        pulse_start(1'b0, 5'd5);
        wait_idx(CNT_W'(3), 50, found);
        chk("t3_reach_idx3", 64'(found), 64'd1);
        rec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            chk("t3_hold_valid", 64'(rec_valid), 64'd1);
            chk("t3_hold_index", 64'(rec_index), 64'd3);
            chk("t3_hold_stim", 64'(rec_stim), 64'd8);
            chk("t3_hold_dut_in", 64'(dut_in), 64'd8);
        end
        rec_ready = 1'b1;
        k = 0;
        while (!(rec_valid && rec_index == CNT_W'(4)) && k < 10) begin
            @(posedge clock); #1;
            k++;
        end
        chk("t3_resume_cycles", 64'(k), 64'd2);
        wait_done("t3", 200);

        // Slow DUT, SETTLE_CYC=4, seed 30 crossing the wrap.
        v4 = 5'd30;
        for (int i = 0; i < NV4; i++) begin
            exp4_q.push_back('{idx: CNT_W'(i), stim: v4, resp: C17_TT[v4]});
            v4 = v4 + 5'd1;
        end
        start4 = 1'b1;
        @(posedge clock); #1;
        start4 = 1'b0;
        k = 0;
        while (!done4 && k < 200) begin
            @(posedge clock); #1;
            k++;
        end
        chk("t4_done", 64'(done4), 64'd1);
        chk("t4_drained", 64'(exp4_q.size()), 64'd0);

        // Reset while record 10 is on offer: record lost, outputs cleared, no more records.
        push_run(1'b0, 5'd0, NV, 1'b0);
        pulse_start(1'b0, 5'd0);
        wait_idx(CNT_W'(10), 100, found);
        chk("t5_reach_idx10", 64'(found), 64'd1);
        rst_n = 1'b0;
        @(posedge clock); #1;
        chk("t5_rst_outputs", {dut_in, rec_valid, rec_index, rec_stim, rec_resp, busy, done}, 64'd0);
        rst_n = 1'b1;
        exp_q.delete();
        seen = 1'b0;
        repeat (20) begin
            @(posedge clock); #1;
            if (rec_valid || busy) seen = 1'b1;
        end
        chk("t5_quiet_after_rst", 64'(seen), 64'd0);

        // Fresh start after reset; a start pulse mid-sweep must not disturb it.
        push_run(1'b0, 5'd0, NV, 1'b0);
        pulse_start(1'b0, 5'd0);
        wait_idx(CNT_W'(5), 50, found);
        chk("t6_reach_idx5", 64'(found), 64'd1);
        pulse_start(1'b1, 5'd9);
        wait_done("t6", 200);

`ifdef PATTERN_SWEEP_SIGNATURE_EN
        push_run(1'b0, 5'd0, NV, 1'b0);
        pulse_start(1'b0, 5'd0);
        wait_done("t7a", 200);
        chk("sig_run1", 64'(sig), 64'(sig_model));
        sig_ref = sig_model;
        push_run(1'b0, 5'd0, NV, 1'b0);
        pulse_start(1'b0, 5'd0);
        wait_done("t7b", 200);
        chk("sig_repeat", 64'(sig), 64'(sig_ref));
        flip = 1'b1;
        push_run(1'b0, 5'd0, NV, 1'b1);
        pulse_start(1'b0, 5'd0);
        wait_done("t7c", 200);
        chk("sig_flip_model", 64'(sig), 64'(sig_model));
        chk("sig_flip_differs", 64'(sig == sig_ref), 64'd0);
        flip = 1'b0;
`endif

        repeat (2) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
